// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: three-requester round-robin arbiter in front of one shared W-bit register.
// A winning request is turned into a one-cycle write (reg_en/reg_d), then a one-cycle ack,
// then the arbiter returns to idle. This gives at most one write every three cycles.
//
// Ports:
//   clk              sole clock, all state updates on its rising edge
//   reset            asynchronous active-low reset
//   req[2:0]         level write requests, bit i belongs to requester i
//   d_req0..d_req2   write data of requesters 0..2
//   gnt[2:0]         one-hot grant, 0 when idle
//   ack[2:0]         one-cycle completion pulse to the granted requester
//   reg_en           write enable to the shared register
//   reg_d[W-1:0]     write data to the shared register
//   busy             high whenever the arbiter is not idle
//   wr_cnt[7:0]      completed-write counter, wraps 255 -> 0
module rr_reg_arbiter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   req,
    input  logic [W-1:0] d_req0,
    input  logic [W-1:0] d_req1,
    input  logic [W-1:0] d_req2,
    output logic [2:0]   gnt,
    output logic [2:0]   ack,
    output logic         reg_en,
    output logic [W-1:0] reg_d,
    output logic         busy,
    output logic [7:0]   wr_cnt
);

    typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

    state_e         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [2:0]     ack_q, ack_d;
    logic           reg_en_q, reg_en_d;
    logic [W-1:0]   reg_d_q, reg_d_d;
    logic           busy_q, busy_d;
    logic [7:0]     wr_cnt_q, wr_cnt_d;

    logic [1:0]     win_idx;
    logic [W-1:0]   win_data;
    logic [1:0]     next_ptr;

    // Round-robin search: look at ptr, ptr+1, ptr+2 (mod 3), first set req wins.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        cand    = 3'd0;
        found   = 1'b0;
        win_idx = ptr_q;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && req[cand[1:0]]) begin
                found   = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd1:    win_data = d_req1;
            2'd2:    win_data = d_req2;
            default: win_data = d_req0;
        endcase
    end

    // Pointer moves to the requester after the one just served, so it ranks last next time.
    always_comb begin
        case (gnt_q)
            3'b001:  next_ptr = 2'd1;
            3'b010:  next_ptr = 2'd2;
            default: next_ptr = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        ack_d    = ack_q;
        reg_en_d = reg_en_q;
        reg_d_d  = reg_d_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d    = 3'b001 << win_idx;
                    reg_d_d  = win_data;
                    reg_en_d = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                reg_en_d = 1'b0;
                ack_d    = gnt_q;
                wr_cnt_d = wr_cnt_q + 8'd1;
                state_d  = StAck;
            end
            StAck: begin
                ack_d   = 3'b000;
                gnt_d   = 3'b000;
                ptr_d   = next_ptr;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ptr_q    <= 2'd0;
            gnt_q    <= 3'b000;
            ack_q    <= 3'b000;
            reg_en_q <= 1'b0;
            reg_d_q  <= '0;
            busy_q   <= 1'b0;
            wr_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            busy_q   <= busy_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = busy_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: a transaction-schedule model checked every cycle plus directed
// scenarios with literal expectations.
module tb_rr_reg_arbiter;

    localparam int unsigned W = 3;

    logic         clk;
    logic         reset;
    logic [2:0]   req;
    logic [W-1:0] d_req0, d_req1, d_req2;
    logic [2:0]   gnt, ack;
    logic         reg_en;
    logic [W-1:0] reg_d;
    logic         busy;
    logic [7:0]   wr_cnt;

    rr_reg_arbiter #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .d_req0 (d_req0),
        .d_req1 (d_req1),
        .d_req2 (d_req2),
        .gnt    (gnt),
        .ack    (ack),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .busy   (busy),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a grant issued at edge g owns the register for edges g..g+2; the write
    // completes (counter bumps) at g+1 and the pointer moves past the winner at g+2.
    int           m_cyc;
    int           m_gedge;
    int           m_win;
    int           m_ptr;
    int           m_cnt;
    logic [W-1:0] m_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc   = 0;
            m_gedge = -100;
            m_win   = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_data  = '0;
        end else begin
            bit finished;
            finished = 1'b0;
            m_cyc++;
            if (m_win >= 0) begin
                if (m_cyc == m_gedge + 1) begin
                    m_cnt = (m_cnt + 1) % 256;
                end else if (m_cyc == m_gedge + 2) begin
                    m_ptr    = (m_win + 1) % 3;
                    m_win    = -1;
                    finished = 1'b1;
                end
            end
            if (m_win < 0 && !finished && req != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    int j;
                    j = (m_ptr + k) % 3;
                    if (m_win < 0 && req[j]) m_win = j;
                end
                m_gedge = m_cyc;
                m_data  = (m_win == 0) ? d_req0 : (m_win == 1) ? d_req1 : d_req2;
            end
        end
    end

    // Per-cycle compare, 2 time units after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                logic [2:0] e_gnt;
                e_gnt = (m_win >= 0) ? (3'b001 << m_win) : 3'b000;
                check("gnt", gnt, e_gnt);
                check("ack", ack, (m_win >= 0 && m_cyc == m_gedge + 1) ? e_gnt : 3'b000);
                check("reg_en", reg_en, (m_win >= 0 && m_cyc == m_gedge) ? 1 : 0);
                check("reg_d", reg_d, m_data);
                check("busy", busy, (m_win >= 0) ? 1 : 0);
                check("wr_cnt", wr_cnt, m_cnt[7:0]);
                check("gnt_onehot0", $onehot0(gnt) ? 1 : 0, 1);
                check("ack_sub_gnt", (ack == 3'b000 || ack == gnt) ? 1 : 0, 1);
            end
        end
    end

    // Inputs change and literal checks happen 3 units after an edge.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [2:0]   rr_gnt [4];
    logic [W-1:0] rr_dat [4];
    int           rr_t   [4];
    int           rr_n;
    logic [2:0]   exp_g  [4];

    initial begin
        req    = 3'b000;
        d_req0 = '0;
        d_req1 = '0;
        d_req2 = '0;
        reset  = 1'b1;
        #1;
        reset  = 1'b0;
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_reg_en", reg_en, 0);
        check("rst_reg_d", reg_d, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single request from requester 1.
        req    = 3'b010;
        d_req1 = 3'b101;
        tick();
        check("single_gnt", gnt, 3'b010);
        check("single_reg_en", reg_en, 1);
        check("single_reg_d", reg_d, 3'b101);
        check("single_busy", busy, 1);
        tick();
        check("single_ack", ack, 3'b010);
        check("single_reg_en_off", reg_en, 0);
        check("single_cnt", wr_cnt, 1);
        req = 3'b000;
        tick();
        check("single_idle_busy", busy, 0);
        check("single_idle_gnt", gnt, 0);
        check("single_idle_ack", ack, 0);

        // Round-robin with all three requesting, from ptr = 0.
        do_reset();
        req    = 3'b111;
        d_req0 = 3'b001;
        d_req1 = 3'b010;
        d_req2 = 3'b100;
        rr_n   = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (reg_en === 1'b1 && rr_n < 4) begin
                rr_gnt[rr_n] = gnt;
                rr_dat[rr_n] = reg_d;
                rr_t[rr_n]   = t;
                rr_n++;
            end
        end
        req = 3'b000;
        tick();
        tick();
        tick();
        exp_g[0] = 3'b001;
        exp_g[1] = 3'b010;
        exp_g[2] = 3'b100;
        exp_g[3] = 3'b001;
        check("rr_count", rr_n, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rr_n) begin
                check("rr_gnt", rr_gnt[k], exp_g[k]);
                check("rr_reg_d", rr_dat[k], exp_g[k]);
                if (k > 0) check("rr_spacing", rr_t[k] - rr_t[k-1], 3);
            end
        end
        check("rr_cnt", wr_cnt, 4);

        // Requester 0 drops its request right after the grant.
        req    = 3'b001;
        d_req0 = 3'b011;
        tick();
        check("drop_reg_en", reg_en, 1);
        check("drop_reg_d", reg_d, 3'b011);
        req    = 3'b000;
        d_req0 = 3'b000;
        tick();
        check("drop_ack", ack, 3'b001);
        check("drop_reg_d_held", reg_d, 3'b011);
        tick();

        // Write 110 from requester 1, then idle for 10 cycles.
        req    = 3'b010;
        d_req1 = 3'b110;
        tick();
        req    = 3'b000;
        tick();
        tick();
        for (int t = 0; t < 10; t++) tick();
        check("idle_reg_en", reg_en, 0);
        check("idle_reg_d", reg_d, 3'b110);
        check("idle_cnt", wr_cnt, 6);

        // Async reset in the middle of the write cycle (ptr is 2 at this point).
        req    = 3'b010;
        d_req1 = 3'b111;
        tick();
        check("abort_pre_reg_en", reg_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_reg_en", reg_en, 0);
        check("abort_gnt", gnt, 0);
        check("abort_busy", busy, 0);
        check("abort_cnt", wr_cnt, 0);
        req = 3'b000;
        tick();
        check("abort_no_ack", ack, 0);
        check("abort_cnt_stays", wr_cnt, 0);
        reset = 1'b1;
        // First arbitration after reset starts from ptr 0.
        req    = 3'b111;
        d_req0 = 3'b001;
        tick();
        check("post_rst_gnt", gnt, 3'b001);
        req = 3'b000;
        tick();
        tick();

        // Counter wrap with requester 2.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req    = 3'b100;
            d_req2 = 3'(i);
            tick();
            req = 3'b000;
            tick();
            tick();
            if (i == 254) check("wrap_255", wr_cnt, 255);
        end
        check("wrap_0", wr_cnt, 0);
        req    = 3'b011;
        d_req0 = 3'b010;
        tick();
        check("wrap_arb_gnt", gnt, 3'b001);
        check("wrap_arb_reg_d", reg_d, 3'b010);
        req = 3'b000;
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 The block SHALL have one parameter, W, default 3: data width of the shared register.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req  input  3  per-requester write request; bit i belongs to requester i; level, held until ack[i].
REQ-005 d_req0, d_req1, d_req2  input  W each  write data of requester 0/1/2; valid while the matching req bit is high.
REQ-006 gnt  output  3  one-hot grant; identifies the requester currently owning the register; 0 when idle.
REQ-007 ack  output  3  one-cycle completion pulse to the granted requester.
REQ-008 reg_en  output  1  write enable to the shared W-bit register.
REQ-009 reg_d  output  W  write data to the shared register.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 wr_cnt  output  8  count of completed writes; wraps from 255 to 0.

Function
REQ-012 All outputs SHALL be driven directly from flops.
REQ-013 The FSM SHALL have three states: IDLE, WRITE and ACK.
REQ-014 IDLE: when req != 0 at a posedge, the block SHALL take all of the following actions on that edge:
- select the winner i;
- set gnt to onehot(i);
- capture d_req<i> into reg_d;
- set reg_en to 1;
- move to WRITE.
REQ-015 IDLE with req == 0: the block SHALL hold state; gnt, ack and reg_en SHALL stay 0, and reg_d SHALL hold its value.
REQ-016 WRITE: at the next posedge the block SHALL clear reg_en, set ack to gnt, increment wr_cnt, and move to ACK.
REQ-017 ACK: at the next posedge the block SHALL clear ack and gnt, set ptr to (i+1) mod 3, and move to IDLE.
REQ-018 reg_en SHALL be high for exactly one cycle per grant, and ack SHALL be high for exactly one cycle per grant.
REQ-019 Latency: reg_en rises 1 edge after the request is seen, and ack rises 2 edges after the request is seen.
REQ-020 Throughput: a new grant SHALL be issued no earlier than 3 edges after the previous grant (at most one write per 3 cycles).
REQ-021 Winner selection SHALL be round-robin: requesters are checked in the order ptr, ptr+1, ptr+2 (mod 3), and the first with req set wins.
REQ-022 ptr is a 2-bit internal pointer with legal values 0..2; it SHALL never take the value 3.
REQ-023 req is sampled only in IDLE; changes to req during WRITE or ACK SHALL be ignored.
REQ-024 If the winner drops its req during WRITE or ACK, the write and ack SHALL still complete using the captured data.
REQ-025 A requester that keeps req high after its ack SHALL be re-arbitrated normally and SHALL lose to any other pending requester.
REQ-026 When all three req bits are high continuously, grants SHALL rotate 0,1,2,0,... starting from the current ptr.
REQ-027 gnt SHALL always be zero or one-hot, and ack SHALL always be zero or equal to gnt.

Reset
REQ-028 reset low SHALL immediately, without waiting for clk, force:
- state = IDLE, ptr = 0, wr_cnt = 0;
- gnt = 0, ack = 0, reg_en = 0, busy = 0;
- reg_d = 0.
REQ-029 Reset asserted during WRITE or ACK SHALL abort the operation: no ack issued, wr_cnt not incremented, reg_en dropped at once.
REQ-030 After reset is released, the first posedge with req != 0 SHALL arbitrate with ptr = 0.

Verification
REQ-031 Single request: reset released, req=3'b010, d_req1=3'b101 at edge E0 -> required response:
- gnt=3'b010 and reg_en=1 with reg_d=3'b101 during E0..E1;
- ack=3'b010 during E1..E2;
- wr_cnt=1, then busy=0 after E2.
REQ-032 Round-robin: req=3'b111 held with data 3'b001/3'b010/3'b100 -> required response:
- grants in the order 001, 010, 100, 001, each spaced 3 cycles apart;
- reg_d follows 001, 010, 100, 001.
REQ-033 Request dropped mid-write: req0 high for one cycle with d_req0=3'b011 -> reg_en pulses with reg_d=3'b011 and ack[0] still pulses.
REQ-034 Async reset: reset driven low halfway through the WRITE cycle -> required response:
- reg_en, gnt and busy go to 0 before the next clk edge;
- no ack is issued and wr_cnt stays 0.
REQ-035 Counter wrap: 256 single writes from requester 2 -> wr_cnt reads 255, then 0, and arbitration is unaffected.
REQ-036 Idle hold: req=0 for 10 cycles after a write of 3'b110 -> reg_en stays 0 and reg_d holds 3'b110.
